mixcol_sequencer: RTL
=====================

MIXCOL_SEQUENCER -- requirements
Module: mixcol_sequencer

Interface
REQ-001 SHALL have ports: clk_in  input  1  single clock; all state changes on the rising edge.
REQ-002 SHALL have port: rst_n_in  input  1  asynchronous reset, active-low.
REQ-003 SHALL have port: start_in  input  1  request to process state_in.
REQ-004 SHALL have port: bypass_in  input  1  sampled with start_in; 1 = final-round pass-through with no MixColumns.
REQ-005 SHALL have port: state_in  input  128  AES state; byte k = state_in[127-8k -: 8]; column c = bytes 4c..4c+3, where byte 4c is row 0.
REQ-006 SHALL have port: ready_out  output  1  high only in IDLE.
REQ-007 SHALL have port: valid_out  output  1  high while the result is held.
REQ-008 SHALL have port: ack_in  input  1  consumer accepts the result.
REQ-009 SHALL have port: state_out  output  128  result, same byte ordering as state_in.
REQ-010 SHALL have port: col_out  output  2  index of the column being processed (debug).

Function
REQ-011 SHALL use one column-mix datapath, four byte-mix slices with rotated inputs, shared across the 4 columns, one column per cycle.
REQ-012 For column (a0,a1,a2,a3), output SHALL be b_r = 2·a_r ^ 3·a_(r+1) ^ a_(r+2) ^ a_(r+3), with indices mod 4; 2· is GF(2^8) xtime, polynomial 0x11B.
REQ-013 SHALL have FSM states IDLE, BUSY, DONE.
REQ-014 IDLE->BUSY SHALL occur on an edge sampling start_in=1; state_in and bypass_in SHALL be captured into an input register, and col_cnt SHALL be set to 0.
REQ-015 In BUSY, each edge SHALL write column col_cnt of the result register and increment col_cnt; after the col_cnt=3 write, the FSM SHALL go to DONE.
REQ-016 Latency SHALL be 4 edges from the accept edge to valid_out=1.
REQ-017 With captured bypass=1, the first BUSY edge SHALL copy all 128 bits unchanged and go to DONE, for a latency of 1 edge.
REQ-018 In DONE, valid_out=1 and state_out SHALL be held stable until an edge samples ack_in=1; the FSM SHALL then go to IDLE.
REQ-019 ready_out SHALL return to 1 on the cycle after the ack edge; there is no back-to-back accept in DONE.
REQ-020 start_in SHALL be ignored outside IDLE.
REQ-021 ack_in SHALL be ignored outside DONE.
REQ-022 state_in changes after the accept edge SHALL NOT affect the result.
REQ-023 col_out SHALL equal col_cnt in BUSY and 0 otherwise.
REQ-024 col_cnt SHALL wrap 3->0 only by leaving BUSY; it SHALL never advance in IDLE or DONE.

Reset
REQ-025 rst_n_in=0 SHALL immediately force IDLE, col_cnt=0, state_out=0, valid_out=0, and ready_out=1, independent of the clock.
REQ-026 Reset during BUSY or DONE SHALL abort the operation and discard the partial result; the first start after release SHALL be processed normally.
REQ-027 Reset release SHALL take effect on the next rising edge; start_in sampled at that edge SHALL be accepted.

Configuration
REQ-028 Macro MIXCOL_DECRYPT_EN: when defined, the block SHALL add port decrypt_in (input, 1), sampled with start_in.
REQ-029 With MIXCOL_DECRYPT_EN defined and decrypt=1, the block SHALL compute InvMixColumns (coefficients 0E,0B,0D,09) with the same latency and handshake; bypass_in SHALL take priority over decrypt_in.
REQ-030 Without MIXCOL_DECRYPT_EN, there SHALL be no decrypt_in port and the block SHALL support forward MixColumns only.

Verification
REQ-031 Reset, then state_in column 0 = db135345 and columns 1..3 = f20a225c, 01010101, d4d4d4d5, start=1, ack held 1 -> state_out = 8e4da1bc 9fdc589d 01010101 d5d5d7d6; valid_out rises exactly 4 edges after accept; col_out steps 0,1,2,3.
REQ-032 Same input with bypass_in=1 -> valid_out after 1 edge; state_out equals state_in.
REQ-033 Hold ack_in=0 for 10 cycles in DONE while toggling start_in and state_in -> state_out and valid_out stable, ready_out=0; on ack, IDLE, then ready_out=1 the next cycle.
REQ-034 Assert rst_n_in=0 mid-BUSY at col_cnt=2 -> outputs reset asynchronously; the next start of 2d26314c repeated in all four columns yields 4d7ebdf8 in each.
REQ-035 With MIXCOL_DECRYPT_EN and decrypt_in=1, input column 8e4da1bc in all four columns -> db135345 in every column, latency 4.

Source files
------------

// File: rtl/mixcol_sequencer.sv
// mixcol_sequencer: AES MixColumns one column per cycle; define MIXCOL_DECRYPT_EN for decrypt_in/InvMixColumns
module mixcol_sequencer (
  input  logic         clk_in,
  input  logic         rst_n_in,
  input  logic         start_in,
  input  logic         bypass_in,
`ifdef MIXCOL_DECRYPT_EN
  input  logic         decrypt_in,
`endif
  input  logic [127:0] state_in,
  output logic         ready_out,
  output logic         valid_out,
  input  logic         ack_in,
  output logic [127:0] state_out,
  output logic [1:0]   col_out
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nx;
  logic [127:0] in_q, res_q;
  logic         byp_q, dec_q;
  logic [1:0]   col_cnt;
  logic [6:0]   base;
  logic [31:0]  col, mixed;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] m(input logic [7:0] x, input logic [3:0] k);
    return (k[0] ? x : 8'h00) ^ (k[1] ? xt(x) : 8'h00) ^ (k[2] ? xt(xt(x)) : 8'h00) ^ (k[3] ? xt(xt(xt(x))) : 8'h00);
  endfunction

  function automatic logic [7:0] slice(input logic [7:0] a, b, c, d, input logic inv);
    return inv ? m(a, 4'hE) ^ m(b, 4'hB) ^ m(c, 4'hD) ^ m(d, 4'h9) : m(a, 4'h2) ^ m(b, 4'h3) ^ c ^ d;
  endfunction

  assign base  = 7'd127 - {col_cnt, 5'd0};
  assign col   = in_q[base -: 32];
  assign mixed = {slice(col[31:24], col[23:16], col[15:8], col[7:0], dec_q),
                  slice(col[23:16], col[15:8], col[7:0], col[31:24], dec_q),
                  slice(col[15:8], col[7:0], col[31:24], col[23:16], dec_q),
                  slice(col[7:0], col[31:24], col[23:16], col[15:8], dec_q)};

  assign ready_out = state == IDLE;
  assign valid_out = state == DONE;
  assign state_out = res_q;
  assign col_out   = state == BUSY ? col_cnt : 2'd0;

  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (start_in ? BUSY : IDLE) :
               state == BUSY ? ((byp_q || col_cnt == 2'd3) ? DONE : BUSY) :
               (ack_in ? IDLE : DONE);
  end

  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) state <= IDLE;
    else state <= state_nx;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      in_q    <= '0;
      res_q   <= '0;
      byp_q   <= 1'b0;
      col_cnt <= 2'd0;
    end else if (state == IDLE && start_in) begin
      in_q    <= state_in;
      byp_q   <= bypass_in;
      col_cnt <= 2'd0;
    end else if (state == BUSY) begin
      if (byp_q) res_q <= in_q;
      else begin
        res_q[base -: 32] <= mixed;
        col_cnt           <= col_cnt + 2'd1;
      end
    end
  end

`ifdef MIXCOL_DECRYPT_EN
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) dec_q <= 1'b0;
    else if (state == IDLE && start_in) dec_q <= decrypt_in;
`else
  assign dec_q = 1'b0;
`endif
endmodule
